// File: rtl/enc_binder_array_tm.sv
// enc_binder_array_tm
// Binds NUM_CH level hypervectors by rotating each one left by a fixed,
// per-channel amount taken from the SHIFTS table.
//
// A start request captures the whole level_hv set. Channels are then written
// to shifted_hv in batches of LANES channels per clock. done pulses for one
// cycle on the edge that writes the last batch. out_valid stays high from
// that edge until the next accepted start.
//
// Every channel's rotation amount is fixed at elaboration, so each rotator is
// plain wiring. A channel's output register is loaded only in the cycle that
// its batch is processed.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start_encoding; shifted_hv holds the last result
// ST_RUN   | writing batch r_batch of the captured set, one batch per clock

module enc_binder_array_tm #(
    parameter int HV_DIM   = 1024,
    parameter int NUM_CH   = 10,
    parameter int LANES    = 2,
    parameter int BASE_IDX = 0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_encoding,
    input  logic [HV_DIM-1:0] level_hv   [0:NUM_CH-1],
    output logic [HV_DIM-1:0] shifted_hv [0:NUM_CH-1],
    output logic              busy,
    output logic              done,
    output logic              out_valid
);

    localparam int NUM_BATCH = (NUM_CH + LANES - 1) / LANES;
    localparam int BW        = (NUM_BATCH > 1) ? $clog2(NUM_BATCH) : 1;
    localparam logic [BW-1:0] LAST_BATCH = BW'(NUM_BATCH - 1);

    // Shared rotation table. BASE_IDX selects where this instance's
    // channels start, so several binders can use disjoint slices of it.
    localparam int SHIFTS_LEN = 32;
    localparam int SHIFTS [0:SHIFTS_LEN-1] = '{
         5,  0,  7, 12,  1, 19,  9, 15,  2, 11,  6, 13,  4,  8, 10, 14,
         3, 17, 21, 25, 29, 33, 37, 41, 45, 49, 53, 57, 61, 65, 69, 73
    };

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic              r_state;
    logic [BW-1:0]     r_batch;
    logic              r_done;
    logic              r_valid;
    logic [HV_DIM-1:0] r_cap [0:NUM_CH-1];
    logic [HV_DIM-1:0] r_out [0:NUM_CH-1];
    logic [HV_DIM-1:0] w_rot [0:NUM_CH-1];
    logic              w_accept;
    logic              w_run;

    assign w_accept = (r_state == ST_IDLE) && start_encoding;
    assign w_run    = (r_state == ST_RUN);

    // A shift of zero reduces to the identity: the right-shift term is
    // a shift by HV_DIM, which yields zero.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_rot
        localparam int SH = SHIFTS[BASE_IDX + g] % HV_DIM;
        assign w_rot[g] = (r_cap[g] << SH) | (r_cap[g] >> (HV_DIM - SH));
    end

    // Control FSM: accept a start in idle, step through the batches, then
    // flag completion.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_batch <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_encoding) begin
                        r_valid <= 1'b0;
                        r_batch <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_batch == LAST_BATCH) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_batch <= r_batch + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Input capture: level_hv is sampled only on the accepting edge, so
    // later changes to it cannot disturb a run in progress.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < NUM_CH; c++) r_cap[c] <= '0;
        end else if (w_accept) begin
            for (int c = 0; c < NUM_CH; c++) r_cap[c] <= level_hv[c];
        end
    end

    // Output write: only the channels of the current batch are loaded. In a
    // partial last batch the unused lanes map to no channel and write nothing.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < NUM_CH; c++) r_out[c] <= '0;
        end else if (w_run) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_batch == BW'(c / LANES)) r_out[c] <= w_rot[c];
            end
        end
    end

    assign shifted_hv = r_out;
    assign busy       = w_run;
    assign done       = r_done;
    assign out_valid  = r_valid;

endmodule

// File: tb/tb_enc_binder_array_tm.sv
// Scoreboard bench for enc_binder_array_tm: a batched instance (LANES=4, P=3)
// and a full-width instance (LANES=NUM_CH, P=1), both with HV_DIM=16.
module tb_enc_binder_array_tm;
    localparam int W = 16;
    localparam int N = 10;
    typedef logic [W-1:0] hv_t;
    typedef logic [W*N-1:0] res_t;

    // Shift per channel for BASE_IDX=0 and HV_DIM=16 (table entry 19 -> 3).
    localparam int S_TB [0:N-1] = '{5, 0, 7, 12, 1, 3, 9, 15, 2, 11};

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic st_a = 1'b0, st_b = 1'b0;
    hv_t  lv_a [0:N-1];
    hv_t  lv_b [0:N-1];
    hv_t  sh_a [0:N-1];
    hv_t  sh_b [0:N-1];
    logic busy_a, done_a, val_a, busy_b, done_b, val_b;

    int   n_vec = 0;
    int   n_err = 0;
    res_t q_a [$];
    res_t q_b [$];
    res_t e_a, e_b;

    enc_binder_array_tm #(.HV_DIM(W), .NUM_CH(N), .LANES(4), .BASE_IDX(0)) u_dut_a (
        .clk(clk), .nrst(nrst), .start_encoding(st_a), .level_hv(lv_a),
        .shifted_hv(sh_a), .busy(busy_a), .done(done_a), .out_valid(val_a)
    );

    enc_binder_array_tm #(.HV_DIM(W), .NUM_CH(N), .LANES(N), .BASE_IDX(0)) u_dut_b (
        .clk(clk), .nrst(nrst), .start_encoding(st_b), .level_hv(lv_b),
        .shifted_hv(sh_b), .busy(busy_b), .done(done_b), .out_valid(val_b)
    );

    function automatic hv_t rot_m(input hv_t v, input int s);
        hv_t r;
        r = '0;
        for (int j = 0; j < W; j++) r[(j + s) % W] = v[j];
        return r;
    endfunction

    function automatic res_t model(input hv_t lv [0:N-1]);
        res_t m;
        for (int i = 0; i < N; i++) m[i*W +: W] = rot_m(lv[i], S_TB[i]);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the batched instance: every done pops one expected result.
    always @(posedge clk) begin
        #2;
        if (done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL mon_a_unexpected_done: got done=1, expected no run pending");
            end else begin
                e_a = q_a.pop_front();
                for (int i = 0; i < N; i++)
                    chk($sformatf("mon_a_ch%0d", i), 32'(sh_a[i]), 32'(e_a[i*W +: W]));
                chk("mon_a_out_valid", 32'(val_a), 32'd1);
            end
        end
    end

    // Monitor for the full-width instance.
    always @(posedge clk) begin
        #2;
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL mon_b_unexpected_done: got done=1, expected no run pending");
            end else begin
                e_b = q_b.pop_front();
                for (int i = 0; i < N; i++)
                    chk($sformatf("mon_b_ch%0d", i), 32'(sh_b[i]), 32'(e_b[i*W +: W]));
                chk("mon_b_out_valid", 32'(val_b), 32'd1);
            end
        end
    end

    initial begin
        hv_t  hand [0:N-1];
        res_t hp;

        for (int i = 0; i < N; i++) begin
            lv_a[i] = '0;
            lv_b[i] = '0;
        end
        step();
        step();
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_valid", 32'(val_a), 32'd0);
        chk("rst_sh3", 32'(sh_a[3]), 32'd0);

        // Basic run, started on the first edge after reset release.
        for (int i = 0; i < N; i++) lv_a[i] = 16'h0001;
        hand = '{16'h0020, 16'h0001, 16'h0080, 16'h1000, 16'h0002,
                 16'h0008, 16'h0200, 16'h8000, 16'h0004, 16'h0800};
        for (int i = 0; i < N; i++) hp[i*W +: W] = hand[i];
        q_a.push_back(hp);
        nrst = 1'b1;
        st_a = 1'b1;
        step();
        st_a = 1'b0;
        chk("basic_busy_k", 32'(busy_a), 32'd1);
        chk("basic_valid_clr", 32'(val_a), 32'd0);
        step();
        chk("basic_busy_k1", 32'(busy_a), 32'd1);
        step();
        chk("basic_busy_k2", 32'(busy_a), 32'd1);
        chk("basic_done_k2", 32'(done_a), 32'd0);
        step();
        chk("basic_done_k3", 32'(done_a), 32'd1);
        chk("basic_busy_k3", 32'(busy_a), 32'd0);
        step();
        chk("basic_done_1cyc", 32'(done_a), 32'd0);
        step();
        step();
        chk("basic_valid_hold", 32'(val_a), 32'd1);

        // Wrap and partial last batch.
        for (int i = 0; i < N; i++) lv_a[i] = 16'h0101 << i;
        lv_a[0] = 16'h8000;
        lv_a[8] = 16'h00F0;
        lv_a[9] = 16'hA5A5;
        q_a.push_back(model(lv_a));
        st_a = 1'b1;
        step();
        st_a = 1'b0;
        chk("wrap_valid_clr", 32'(val_a), 32'd0);
        step();
        chk("wrap_ch0_b0", 32'(sh_a[0]), 32'h0010);
        chk("wrap_ch8_hold", 32'(sh_a[8]), 32'h0004);
        step();
        chk("wrap_ch9_hold", 32'(sh_a[9]), 32'h0800);
        step();
        chk("wrap_done", 32'(done_a), 32'd1);
        chk("wrap_ch8", 32'(sh_a[8]), 32'h03C0);
        chk("wrap_ch9", 32'(sh_a[9]), 32'h2D2D);
        step();

        // Start during RUN is ignored; results come from the first capture.
        for (int i = 0; i < N; i++) lv_a[i] = 16'h1234 ^ hv_t'(i * 16'h1111);
        q_a.push_back(model(lv_a));
        st_a = 1'b1;
        step();
        for (int i = 0; i < N; i++) lv_a[i] = 16'hFFFF;
        step();
        st_a = 1'b0;
        step();
        step();
        chk("ign_done", 32'(done_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ign_no_rerun", 32'(busy_a), 32'd0);
        end

        // Reset asserted mid-run aborts with no done.
        for (int i = 0; i < N; i++) lv_a[i] = 16'h00FF;
        q_a.push_back(model(lv_a));
        st_a = 1'b1;
        step();
        st_a = 1'b0;
        step();
        nrst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_valid", 32'(val_a), 32'd0);
        chk("abort_sh0", 32'(sh_a[0]), 32'd0);
        chk("abort_sh5", 32'(sh_a[5]), 32'd0);
        q_a.delete();
        q_b.delete();
        step();
        chk("abort_done", 32'(done_a), 32'd0);
        step();
        nrst = 1'b1;
        step();
        step();
        chk("abort_idle", 32'(busy_a), 32'd0);
        for (int i = 0; i < N; i++) lv_a[i] = 16'hC003 + hv_t'(i);
        q_a.push_back(model(lv_a));
        st_a = 1'b1;
        step();
        st_a = 1'b0;
        step();
        step();
        step();
        chk("restart_done", 32'(done_a), 32'd1);
        step();

        // start held high for 8 cycles: captures at k and k+4.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) lv_a[i] = hv_t'(k * 16'h1000 + i * 16'h0011 + 1);
            if (k == 0 || k == 4) q_a.push_back(model(lv_a));
            st_a = 1'b1;
            step();
            chk($sformatf("b2b_done_%0d", k), 32'(done_a), (k == 3 || k == 7) ? 32'd1 : 32'd0);
        end
        st_a = 1'b0;
        step();
        chk("b2b_stop", 32'(busy_a), 32'd0);

        // Full-width instance: done one cycle after capture, random data.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) lv_b[i] = hv_t'($urandom);
            q_b.push_back(model(lv_b));
            st_b = 1'b1;
            step();
            st_b = 1'b0;
            chk("full_busy", 32'(busy_b), 32'd1);
            chk("full_done_k", 32'(done_b), 32'd0);
            step();
            chk("full_done_k1", 32'(done_b), 32'd1);
            chk("full_busy_k1", 32'(busy_b), 32'd0);
            step();
        end

        step();
        step();
        chk("queue_a_empty", 32'(q_a.size()), 32'd0);
        chk("queue_b_empty", 32'(q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/enc_binder_array_tm.md
ENC_BINDER_ARRAY_TM -- requirements
Module: enc_binder_array_tm

Interface
REQ-001 SHALL have parameter HV_DIM, default 1024: hypervector width in bits.
REQ-002 SHALL have parameter NUM_CH, default 10: number of level-HV channels bound per encoding.
REQ-003 SHALL have parameter LANES, default 2: physical rotators, 1 <= LANES <= NUM_CH.
REQ-004 SHALL have parameter BASE_IDX, default 0: first index into the shared SHIFTS table.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port start_encoding, input, 1 bit: request to bind the current level_hv set.
REQ-008 SHALL have port level_hv, input, [HV_DIM-1:0] x [0:NUM_CH-1]: level hypervectors.
REQ-009 SHALL have port shifted_hv, output, [HV_DIM-1:0] x [0:NUM_CH-1]: bound, rotated hypervectors, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while state is RUN.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when all channels are written.
REQ-012 SHALL have port out_valid, output, 1 bit: shifted_hv holds a complete, current result.

Function
REQ-013 SHALL define S_i = SHIFTS[BASE_IDX+i] mod HV_DIM for channel i, fixed at elaboration.
REQ-014 SHALL define the rotate as left circular rotation: out[(j+S_i) mod HV_DIM] = in[j] for all j. S_i=0 passes data unchanged.
REQ-015 SHALL define P = ceil(NUM_CH/LANES) as the batch count, with batch counter width clog2(P) (min 1 bit).
REQ-016 SHALL implement FSM states IDLE and RUN.
REQ-017 In IDLE with start_encoding=1 at an edge, the block SHALL capture all level_hv into the input register, clear out_valid, reset the batch counter to 0 and go to RUN.
REQ-018 At each edge in RUN with batch b, the block SHALL write shifted_hv[c] = rot(captured[c], S_c) for c = b*LANES .. min((b+1)*LANES, NUM_CH)-1. All other shifted_hv entries SHALL hold their values.
REQ-019 For a partial last batch, lanes with c >= NUM_CH SHALL write nothing.
REQ-020 At the edge processing batch P-1, the block SHALL return to IDLE, set out_valid=1 and register done=1 for exactly one cycle.
REQ-021 Latency SHALL be: start sampled at edge k, done and out_valid high after edge k+P, busy high after edges k..k+P-1.
REQ-022 start_encoding in RUN SHALL be ignored and not queued. Inputs SHALL NOT be re-sampled mid-run.
REQ-023 start_encoding held high SHALL restart on the first IDLE edge after done, i.e. back-to-back period P+1 cycles.
REQ-024 level_hv changes after the capture edge SHALL NOT affect the current run.
REQ-025 When LANES = NUM_CH (P=1), done SHALL follow the capture edge by exactly one cycle.
REQ-026 out_valid SHALL stay high in IDLE until the next accepted start_encoding.

Reset
REQ-027 nrst=0 SHALL asynchronously force state IDLE, batch counter 0, busy=0, done=0, out_valid=0, all shifted_hv and captured registers to 0.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse. After release, the block SHALL wait in IDLE for a new start_encoding.
REQ-029 start_encoding sampled at the first edge after nrst release SHALL be accepted.

Verification
REQ-030 Basic run: HV_DIM=16, NUM_CH=10, LANES=4, level_hv[i]=16'h0001 for all i, start pulse at edge k -> busy high for 3 cycles, done pulse after edge k+3, shifted_hv[i]=16'h0001<<S_i.
REQ-031 Wrap: level_hv[0]=16'h8000 with S_0 != 0 -> shifted_hv[0]=16'h0001<<(S_0-1). Channels 8..9 are written in batch 2; lanes 2..3 write nothing.
REQ-032 Ignored start: start_encoding re-pulsed at edge k+1 with new data -> single done at k+3, results from the edge-k capture, no second run.
REQ-033 Reset abort: nrst low during the cycle after edge k+1 -> all outputs 0 immediately, no done. A new start after release completes in 3 cycles.
REQ-034 Back-to-back: start_encoding held high for 8 cycles -> done pulses 4 cycles apart, each reflecting level_hv at its capture edge.
REQ-035 Full-width config: LANES=NUM_CH=10 -> done one cycle after capture. A random level_hv set matches a golden rotate model for all channels.
